// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard / memory-wait controller.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
package pipe_ctrl_pkg;

    // Register-file address width
    localparam int unsigned REG_ADDR_W          = 5;

    // Default bound on extra request cycles before a memory access is declared dead
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

    // Wait-counter and performance-counter widths
    localparam int unsigned WAIT_CNT_W          = 8;
    localparam int unsigned STALL_CNT_W         = 32;
    localparam int unsigned FLUSH_CNT_W         = 16;

    // Controller state encoding
    localparam int unsigned STATE_W             = 2;
    localparam logic [STATE_W-1:0] ST_RUN       = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEMWAIT   = 2'd1;
    localparam logic [STATE_W-1:0] ST_ERROR     = 2'd2;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID. Register 0 never creates a dependency.
module pipe_ctrl_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic                  memRead,
    input  logic [REG_ADDR_W-1:0] exRtAddr,
    input  logic [REG_ADDR_W-1:0] idRsAddr,
    input  logic [REG_ADDR_W-1:0] idRtAddr,
    output logic                  loadUse_c
);

    // Pure comparator, no state
    always_comb begin
        loadUse_c = 1'b0;
        if (memRead && (exRtAddr != '0)) begin
            loadUse_c = (exRtAddr == idRsAddr) || (exRtAddr == idRtAddr);
        end
    end

endmodule : pipe_ctrl_hazard_cmp

// File: rtl/pipeline_ctrl.sv
// Pipeline control: data-memory wait/timeout FSM, load-use stall, branch flush.
// Priority is freeze > load-use > flush; hazards are never latched, they are
// re-evaluated from live inputs every cycle.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
)
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [REG_ADDR_W-1:0]  IF_ID_RsAddr_i,
    input  logic [REG_ADDR_W-1:0]  IF_ID_RtAddr_i,
    input  logic                   ID_EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  ID_EX_RtAddr_i,
    input  logic                   Branch_Taken_i,
    input  logic                   EX_MEM_MemAccess_i,
    input  logic                   DMem_Ack_i,
    output logic                   DMem_Req_o,
    output logic                   PC_Write_o,
    output logic                   IF_ID_Write_o,
    output logic                   ID_EX_Write_o,
    output logic                   EX_MEM_Write_o,
    output logic                   IF_ID_Flush_o,
    output logic                   ID_EX_Bubble_o,
    output logic                   MEM_WB_Bubble_o,
    output logic                   MemErr_o,
    output logic [STALL_CNT_W-1:0] StallCnt_o,
    output logic [FLUSH_CNT_W-1:0] FlushCnt_o
);

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    stateNext;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cntNext;
    logic                  loadUse;
    logic                  freeze;

    // Load-use comparator
    pipe_ctrl_hazard_cmp uHazardCmp (
        .memRead   (ID_EX_MemRead_i),
        .exRtAddr  (ID_EX_RtAddr_i),
        .idRsAddr  (IF_ID_RsAddr_i),
        .idRtAddr  (IF_ID_RtAddr_i),
        .loadUse_c (loadUse)
    );

    // State and wait-counter register; reset abandons any pending access
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state and stage-control outputs
    always_comb begin
        stateNext       = state;
        cntNext         = cnt;
        DMem_Req_o      = 1'b0;
        freeze          = 1'b0;
        PC_Write_o      = 1'b1;
        IF_ID_Write_o   = 1'b1;
        ID_EX_Write_o   = 1'b1;
        EX_MEM_Write_o  = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Bubble_o  = 1'b0;
        MEM_WB_Bubble_o = 1'b0;
        MemErr_o        = 1'b0;

        // A dead memory stops all requests; otherwise MEM drives the strobe
        DMem_Req_o = (state != ST_ERROR) && EX_MEM_MemAccess_i;
        freeze     = (DMem_Req_o && !DMem_Ack_i) || (state == ST_ERROR);
        MemErr_o   = (state == ST_ERROR);

        case (state)
            ST_RUN: begin
                // Ack in the request cycle costs nothing
                if (freeze) begin
                    stateNext = ST_MEMWAIT;
                    cntNext   = WAIT_CNT_W'(1);
                end
            end
            ST_MEMWAIT: begin
                if (DMem_Ack_i) begin
                    stateNext = ST_RUN;
                    cntNext   = '0;
                end else if (cnt == WAIT_CNT_W'(MEM_TIMEOUT)) begin
                    stateNext = ST_ERROR;
                end else begin
                    cntNext = WAIT_CNT_W'(cnt + WAIT_CNT_W'(1));
                end
            end
            ST_ERROR: begin
                // Only reset leaves this state
                stateNext = ST_ERROR;
            end
            default: begin
                stateNext = ST_RUN;
                cntNext   = '0;
            end
        endcase

        if (freeze) begin
            // Whole pipeline holds; WB sees a NOP
            PC_Write_o      = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Write_o  = 1'b0;
            MEM_WB_Bubble_o = 1'b1;
        end else if (loadUse) begin
            // Hold fetch/decode, push a bubble into EX
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (Branch_Taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end

        // Reset forces a quiet pipeline regardless of state
        if (!rst_n_i) begin
            DMem_Req_o      = 1'b0;
            PC_Write_o      = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Write_o  = 1'b0;
            IF_ID_Flush_o   = 1'b0;
            ID_EX_Bubble_o  = 1'b1;
            MEM_WB_Bubble_o = 1'b1;
            MemErr_o        = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stallCnt;
    logic [FLUSH_CNT_W-1:0] flushCnt;
    logic                   stallEv;
    logic                   flushEv;

    assign stallEv = freeze || loadUse;
    assign flushEv = IF_ID_Flush_o;

    // Saturating stall/flush counters
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallEv && (stallCnt != '1)) begin
                stallCnt <= stallCnt + STALL_CNT_W'(1);
            end
            if (flushEv && (flushCnt != '1)) begin
                flushCnt <= flushCnt + FLUSH_CNT_W'(1);
            end
        end
    end

    assign StallCnt_o = stallCnt;
    assign FlushCnt_o = flushCnt;
`else
    assign StallCnt_o = '0;
    assign FlushCnt_o = '0;
`endif

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_pipeline_ctrl;

    localparam int unsigned MEM_TIMEOUT = 15;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_EX_RtAddr_i;
    logic        ID_EX_MemRead_i, Branch_Taken_i, EX_MEM_MemAccess_i, DMem_Ack_i;
    logic        DMem_Req_o, PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o;
    logic        IF_ID_Flush_o, ID_EX_Bubble_o, MEM_WB_Bubble_o, MemErr_o;
    logic [31:0] StallCnt_o;
    logic [15:0] FlushCnt_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: dead-memory flag, unacked request cycles, event totals
    bit          mErr = 1'b0;
    int unsigned pending = 0;
    int unsigned sc = 0;
    int unsigned fc = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .IF_ID_RsAddr_i(IF_ID_RsAddr_i), .IF_ID_RtAddr_i(IF_ID_RtAddr_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RtAddr_i(ID_EX_RtAddr_i),
        .Branch_Taken_i(Branch_Taken_i), .EX_MEM_MemAccess_i(EX_MEM_MemAccess_i),
        .DMem_Ack_i(DMem_Ack_i), .DMem_Req_o(DMem_Req_o),
        .PC_Write_o(PC_Write_o), .IF_ID_Write_o(IF_ID_Write_o),
        .ID_EX_Write_o(ID_EX_Write_o), .EX_MEM_Write_o(EX_MEM_Write_o),
        .IF_ID_Flush_o(IF_ID_Flush_o), .ID_EX_Bubble_o(ID_EX_Bubble_o),
        .MEM_WB_Bubble_o(MEM_WB_Bubble_o), .MemErr_o(MemErr_o),
        .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic cycle(input string tag, input bit r, input bit acc, input bit ack,
                         input bit mr, input logic [4:0] exRt, input logic [4:0] rs,
                         input logic [4:0] rt, input bit br);
        bit         req, frz, lu, fl;
        logic [8:0] exp, obs;
        @(negedge clk_i);
        rst_n_i = r; EX_MEM_MemAccess_i = acc; DMem_Ack_i = ack;
        ID_EX_MemRead_i = mr; ID_EX_RtAddr_i = exRt;
        IF_ID_RsAddr_i = rs; IF_ID_RtAddr_i = rt; Branch_Taken_i = br;
        #1;
        lu  = mr && (exRt != 5'd0) && ((exRt == rs) || (exRt == rt));
        req = r && !mErr && acc;
        frz = r && (mErr || (req && !ack));
        fl  = r && !frz && !lu && br;
        // order: req, pc, ifid, idex, exmem, flush, bubIdEx, bubMemWb, err
        if (!r)       exp = 9'b0_0000_0110;
        else if (frz) exp = {req, 4'b0000, 1'b0, 1'b0, 1'b1, mErr};
        else if (lu)  exp = {req, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0};
        else          exp = {req, 4'b1111, fl, 1'b0, 1'b0, 1'b0};
        obs = {DMem_Req_o, PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o,
               IF_ID_Flush_o, ID_EX_Bubble_o, MEM_WB_Bubble_o, MemErr_o};
        check({tag, "_ctrl"}, 32'(obs), 32'(exp));
        check({tag, "_stall"}, StallCnt_o, PERF ? 32'(sc) : 32'd0);
        check({tag, "_flush"}, 32'(FlushCnt_o), PERF ? 32'(fc) : 32'd0);
        if (!r) begin
            mErr = 1'b0; pending = 0; sc = 0; fc = 0;
        end else begin
            if ((frz || lu) && sc != 32'hFFFF_FFFF) sc++;
            if (fl && fc != 32'h0000_FFFF) fc++;
            if (!mErr) begin
                if (req && ack) pending = 0;
                else if (req) begin
                    pending++;
                    if (pending > MEM_TIMEOUT) mErr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst_n_i = 1'b0; EX_MEM_MemAccess_i = 1'b0; DMem_Ack_i = 1'b0;
        ID_EX_MemRead_i = 1'b0; ID_EX_RtAddr_i = '0; IF_ID_RsAddr_i = '0;
        IF_ID_RtAddr_i = '0; Branch_Taken_i = 1'b0;

        // Reset with busy inputs: quiet outputs, no request
        cycle("rst0", 0, 1, 0, 1, 5'd3, 5'd3, 5'd1, 1);
        cycle("rst1", 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1);

        // Zero-stall access
        cycle("ackNow", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("ackNowIdle", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("ackNowStall", StallCnt_o, 32'd0);

        // Ack on 4th request cycle
        cycle("wrst", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 3; i++) cycle("wait", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("waitAck", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("waitIdle", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("wait4Stall", StallCnt_o, PERF ? 32'd3 : 32'd0);

        // Load-use, then the same with register 0
        cycle("luHit", 1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        check("luPcWrite", 32'(PC_Write_o), 32'd0);
        cycle("luZero", 1, 0, 0, 1, 5'd0, 5'd1, 5'd0, 0);
        check("luZeroPcWrite", 32'(PC_Write_o), 32'd1);

        // Branch suppressed by load-use, flushes next cycle
        cycle("brRst", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("brLu", 1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1);
        check("brLuFlush", 32'(IF_ID_Flush_o), 32'd0);
        cycle("brGo", 1, 0, 0, 0, 5'd7, 5'd7, 5'd2, 1);
        check("brGoFlush", 32'(IF_ID_Flush_o), 32'd1);
        cycle("brIdle", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("brFlushCnt", 32'(FlushCnt_o), PERF ? 32'd1 : 32'd0);

        // Freeze, load-use and branch together
        cycle("all3", 1, 1, 0, 1, 5'd4, 5'd4, 5'd4, 1);
        check("all3Bubble", {30'd0, ID_EX_Bubble_o, IF_ID_Flush_o}, 32'd0);
        cycle("all3Ack", 1, 1, 1, 1, 5'd4, 5'd4, 5'd4, 1);

        // Timeout: 16 frozen request cycles, then error until reset
        for (int i = 0; i < 16; i++) cycle("tmo", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("tmoErr", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("tmoMemErr", {30'd0, MemErr_o, DMem_Req_o}, 32'd2);
        cycle("tmoHold", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1);
        cycle("tmoRst", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("tmoClear", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("tmoCleared", 32'(MemErr_o), 32'd0);

        // Random traffic; accesses in flight are held until ack or timeout
        for (int i = 0; i < 1500; i++) begin
            bit r, acc;
            r   = ($urandom_range(0, 60) != 0);
            acc = (pending != 0 && !mErr) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle("rnd", r, acc, ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipeline_ctrl
